// File: rtl/ddp_req_arb_if.sv
// Requester/issue-side bundle for ddp_req_arb: per-requester request bus,
// header-generator strobe, send-done return and status.
interface ddp_req_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    reqValid;
    logic [NUM_REQ*56-1:0] reqHeader;
    logic [NUM_REQ*8-1:0]  reqCtrl;
    logic [NUM_REQ-1:0]    reqAck;
    logic                  pkgFifoFull;
    logic                  sendDoneValid;
    logic                  rdmap2DdpHdrValid;
    logic [55:0]           rdmap2DdpHeader;
    logic [7:0]            rdmap2DdpCtrl;
    logic [7:0]            outstCnt;
    logic                  arbBusy;
    logic [1:0]            dbgState;

    // Handshake: a requester raises reqValid[i] and holds header/ctrl stable
    // until the cycle reqAck[i] pulses; that pulse coincides with the single
    // rdmap2DdpHdrValid strobe carrying the same header/ctrl.
    modport slave (
        input  reqValid, reqHeader, reqCtrl, pkgFifoFull, sendDoneValid,
        output reqAck, rdmap2DdpHdrValid, rdmap2DdpHeader, rdmap2DdpCtrl,
        output outstCnt, arbBusy, dbgState
    );

    modport master (
        output reqValid, reqHeader, reqCtrl, pkgFifoFull, sendDoneValid,
        input  reqAck, rdmap2DdpHdrValid, rdmap2DdpHeader, rdmap2DdpCtrl,
        input  outstCnt, arbBusy, dbgState
    );
endinterface

// File: rtl/ddp_req_arb.sv
// Round-robin RDMAP request arbiter feeding the DDP header generator, with an
// outstanding-message limit. Optional macro DDP_ARB_STRICT_PRIO_EN gives requester 0 strict priority.
module ddp_req_arb #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 8
) (
    input  logic          clock,
    input  logic          reset,
    ddp_req_arb_if.slave  bus
);
    localparam int         PTR_W   = $clog2(NUM_REQ);
    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTST);
`ifdef DDP_ARB_STRICT_PRIO_EN
    localparam bit STRICT_PRIO = 1'b1;
`else
    localparam bit STRICT_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               hdr_vld_q, hdr_vld_d;
    logic [55:0]        hdr_q, hdr_d;
    logic [7:0]         ctrl_q, ctrl_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [PTR_W-1:0]   win_idx;
    int                 idx;
    logic               eligible;
    logic               issue;

    // Scan from rr_ptr upward; in strict mode requester 0 pre-empts the scan
    // and is excluded from the rotation.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        if (STRICT_PRIO && bus.reqValid[0]) begin
            found = 1'b1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.reqValid[idx] && !(STRICT_PRIO && idx == 0)) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    assign eligible = (|bus.reqValid) && !bus.pkgFifoFull && (cnt_q < MAX_CNT);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        ack_d    = '0;
        hdr_d    = hdr_q;
        ctrl_d   = ctrl_q;
        issue    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (eligible && found) begin
                    win_d          = win_idx;
                    hdr_d          = bus.reqHeader[56*int'(win_idx) +: 56];
                    ctrl_d         = bus.reqCtrl[8*int'(win_idx) +: 8];
                    ack_d[win_idx] = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                issue   = 1'b1;
                state_d = GAP;
                if (!(STRICT_PRIO && win_q == '0)) begin
                    rr_ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        hdr_vld_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
    end

    // The message is counted on leaving ISSUE, so a reset during ISSUE drops it.
    always_comb begin
        cnt_d = cnt_q;
        case ({issue, bus.sendDoneValid})
            2'b10:   cnt_d = cnt_q + 8'd1;
            2'b01:   if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            ack_q     <= '0;
            hdr_vld_q <= 1'b0;
            hdr_q     <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            ack_q     <= ack_d;
            hdr_vld_q <= hdr_vld_d;
            hdr_q     <= hdr_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.reqAck            = ack_q;
    assign bus.rdmap2DdpHdrValid = hdr_vld_q;
    assign bus.rdmap2DdpHeader   = hdr_q;
    assign bus.rdmap2DdpCtrl     = ctrl_q;
    assign bus.outstCnt          = cnt_q;
    assign bus.arbBusy           = busy_q;
    assign bus.dbgState          = state_q;
endmodule

// File: tb/tb_ddp_req_arb.sv
// Directed bench for ddp_req_arb: stimulus pushes expected grants into a queue,
// a negedge monitor pops and compares each header strobe.
module tb_ddp_req_arb;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [71:0] exp_q[$];
    logic [71:0] mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddp_req_arb_if #(.NUM_REQ(N)) bus();

    ddp_req_arb #(.NUM_REQ(N), .MAX_OUTST(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    function automatic logic [55:0] hdr_of(int i);
        return 56'hA5 + 56'(i) * 56'h11_2233_4455_6600;
    endfunction

    function automatic logic [7:0] ctrl_of(int i);
        return 8'h03 + 8'(i) * 8'h10;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic push_exp(input int id);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        exp_q.push_back({4'b0000, oh, hdr_of(id), ctrl_of(id)});
    endtask

    // Monitor: every strobe must match the oldest expected grant.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rdmap2DdpHdrValid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: ack=%b hdr=%h ctrl=%h, expected no strobe",
                             bus.reqAck, bus.rdmap2DdpHeader, bus.rdmap2DdpCtrl);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("issue_ack_hdr_ctrl",
                          {4'b0000, bus.reqAck, bus.rdmap2DdpHeader, bus.rdmap2DdpCtrl}, mon_e);
                    check("issue_busy", 72'(bus.arbBusy), 72'd1);
                end
            end else if (bus.reqAck != '0) begin
                check("ack_without_strobe", 72'(bus.reqAck), 72'd0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.reqValid      = '0;
        bus.pkgFifoFull   = 1'b0;
        bus.sendDoneValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",     72'(bus.reqAck), 72'd0);
        check("rst_valid",   72'(bus.rdmap2DdpHdrValid), 72'd0);
        check("rst_header",  72'(bus.rdmap2DdpHeader), 72'd0);
        check("rst_ctrl",    72'(bus.rdmap2DdpCtrl), 72'd0);
        check("rst_outst",   72'(bus.outstCnt), 72'd0);
        check("rst_busy",    72'(bus.arbBusy), 72'd0);
        check("queue_drained", 72'(exp_q.size()), 72'd0);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Waits for n grants; every pair of grants while requests are held must be 3 cycles apart.
    task automatic run_seq(input int n, input bit done_each, input logic [3:0] after_v);
        int seen;
        int last;
        int budget;
        seen = 0;
        last = -1;
        budget = 0;
        while (seen < n && budget < 3 * n + 12) begin
            @(posedge clk);
            #1;
            budget++;
            bus.sendDoneValid = 1'b0;
            if (bus.reqAck != '0) begin
                if (last >= 0) check("issue_spacing", 72'(cyc - last), 72'd3);
                last = cyc;
                seen++;
                if (done_each) bus.sendDoneValid = 1'b1;
                if (seen == n) bus.reqValid = after_v;
            end
        end
        check("grant_count", 72'(seen), 72'(n));
        @(posedge clk);
        #1;
        bus.sendDoneValid = 1'b0;
    endtask

    task automatic idle_cycles(input int n, output int acks);
        acks = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.reqAck != '0 || bus.rdmap2DdpHdrValid) acks++;
        end
    endtask

    task automatic pulse_done();
        bus.sendDoneValid = 1'b1;
        @(posedge clk);
        #1;
        bus.sendDoneValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acks;
        int lat;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.reqHeader[56*i +: 56] = hdr_of(i);
            bus.reqCtrl[8*i +: 8]     = ctrl_of(i);
        end

        // Single request: one-cycle latency, registered outputs, count of one.
        do_reset();
        push_exp(0);
        bus.reqValid = 4'b0001;
        @(posedge clk);
        #1;
        check("t1_ack",    72'(bus.reqAck), 72'h1);
        check("t1_valid",  72'(bus.rdmap2DdpHdrValid), 72'd1);
        check("t1_header", 72'(bus.rdmap2DdpHeader), 72'hA5);
        check("t1_ctrl",   72'(bus.rdmap2DdpCtrl), 72'h03);
        bus.reqValid = 4'b0000;
        @(posedge clk);
        #1;
        check("t1_gap_valid", 72'(bus.rdmap2DdpHdrValid), 72'd0);
        check("t1_gap_busy",  72'(bus.arbBusy), 72'd1);
        check("t1_outst",     72'(bus.outstCnt), 72'd1);
        @(posedge clk);
        #1;
        check("t1_idle_busy",   72'(bus.arbBusy), 72'd0);
        check("t1_header_hold", 72'(bus.rdmap2DdpHeader), 72'hA5);

        // Round robin over all four with a send-done on every issue.
        do_reset();
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        bus.reqValid = 4'b1111;
        run_seq(5, 1'b1, 4'b0000);
        check("t2_outst", 72'(bus.outstCnt), 72'd0);

        // Outstanding limit of 8, one done releases exactly one more issue.
        do_reset();
        for (int i = 0; i < 8; i++) push_exp(i % 4);
        bus.reqValid = 4'b1111;
        run_seq(8, 1'b0, 4'b1111);
        idle_cycles(12, acks);
        check("t3_blocked", 72'(acks), 72'd0);
        check("t3_outst_full", 72'(bus.outstCnt), 72'd8);
        push_exp(0);
        pulse_done();
        run_seq(1, 1'b0, 4'b1111);
        idle_cycles(12, acks);
        check("t3_blocked_again", 72'(acks), 72'd0);
        check("t3_outst_refull", 72'(bus.outstCnt), 72'd8);
        bus.reqValid = 4'b0000;

        // Backpressure holds off the grant; release grants requester 2.
        do_reset();
        bus.pkgFifoFull = 1'b1;
        bus.reqValid = 4'b0100;
        idle_cycles(10, acks);
        check("t4_full_no_ack", 72'(acks), 72'd0);
        push_exp(2);
        bus.pkgFifoFull = 1'b0;
        lat = 0;
        while (lat < 6 && bus.reqAck == '0) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("t4_release_ack", 72'(bus.reqAck), 72'h4);
        check("t4_release_latency_ok", 72'(lat >= 1 && lat <= 2), 72'd1);
        bus.reqValid = 4'b0000;
        idle_cycles(2, acks);
        check("t4_outst", 72'(bus.outstCnt), 72'd1);

        // Issue coinciding with done at 3; done at 0 does not underflow.
        do_reset();
        push_exp(0); push_exp(0); push_exp(0);
        bus.reqValid = 4'b0001;
        run_seq(3, 1'b0, 4'b0001);
        check("t5_outst3", 72'(bus.outstCnt), 72'd3);
        push_exp(0);
        run_seq(1, 1'b1, 4'b0000);
        check("t5_issue_and_done", 72'(bus.outstCnt), 72'd3);
        pulse_done();
        pulse_done();
        pulse_done();
        check("t5_outst0", 72'(bus.outstCnt), 72'd0);
        pulse_done();
        check("t5_no_underflow", 72'(bus.outstCnt), 72'd0);

        // Priority behaviour with requesters 0..2, then with requester 0 dropped.
        do_reset();
`ifdef DDP_ARB_STRICT_PRIO_EN
        push_exp(0); push_exp(0); push_exp(0);
        bus.reqValid = 4'b0111;
        run_seq(3, 1'b1, 4'b0110);
`else
        push_exp(0); push_exp(1); push_exp(2); push_exp(0);
        bus.reqValid = 4'b0111;
        run_seq(4, 1'b1, 4'b0110);
`endif
        push_exp(1); push_exp(2); push_exp(1); push_exp(2);
        run_seq(4, 1'b1, 4'b0000);

        // Reset during ISSUE drops strobe and ack at once and does not count the message.
        do_reset();
        bus.reqValid = 4'b0001;
        @(posedge clk);
        #1;
        check("t7_pre_reset_ack", 72'(bus.reqAck), 72'h1);
        rst = 1'b1;
        bus.reqValid = 4'b0000;
        #1;
        check("t7_valid_dropped", 72'(bus.rdmap2DdpHdrValid), 72'd0);
        check("t7_ack_dropped",   72'(bus.reqAck), 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(3, acks);
        check("t7_outst", 72'(bus.outstCnt), 72'd0);

        idle_cycles(2, acks);
        check("final_queue_empty", 72'(exp_q.size()), 72'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
